// File: rtl/out_channel_checker.sv
// Receiving end of the program out channel: records emitted words into a
// circular buffer and compares it against a host-loaded expected table on halt.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 6,
  parameter int IW                 = $clog2(NOut + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [IW-1:0]                 load_index,
  input  logic [MemoryElementWidth-1:0] load_data,
  input  logic                          start,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  input  logic                          halt,
  output logic                          finished,
  output logic                          success,
  output logic [15:0]                   count,
  output logic [IW-1:0]                 mismatch_index
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DONE} state_t;

  localparam logic [IW-1:0] NoMismatch = IW'(NOut);
  localparam logic [IW-1:0] LastIndex  = IW'(NOut - 1);

  state_t                        state;
  logic [MemoryElementWidth-1:0] capt_mem [NOut];
  logic [MemoryElementWidth-1:0] expected [NOut];
  logic [NOut-1:0]               written;
  logic [IW-1:0]                 wp;
  logic [IW-1:0]                 chk_idx;
  logic                          xfer;
  logic                          load_ok;
  logic                          entry_fail;

  assign out_ready  = (state == CAPTURE);
  assign xfer       = out_valid && out_ready;
  assign load_ok    = load_valid && (state == IDLE || state == DONE) &&
                      (load_index < NoMismatch);
  assign entry_fail = !written[chk_idx] || (capt_mem[chk_idx] != expected[chk_idx]);

  // NOTE: the data arrays carry no reset; validity is tracked by the written
  // flags, and the expected table must survive reset so the host loads it once.
  always_ff @(posedge clock) begin
    if (load_ok) expected[load_index] <= load_data;
    if (xfer)    capt_mem[wp]         <= out_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      finished       <= 1'b0;
      success        <= 1'b0;
      count          <= '0;
      mismatch_index <= NoMismatch;
      wp             <= '0;
      chk_idx        <= '0;
      written        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= CAPTURE;
            finished       <= 1'b0;
            success        <= 1'b0;
            count          <= '0;
            mismatch_index <= NoMismatch;
            wp             <= '0;
            written        <= '0;
          end
        end
        CAPTURE: begin
          // A word presented together with halt is still captured.
          if (xfer) begin
            written[wp] <= 1'b1;
            wp          <= (wp == LastIndex) ? '0 : wp + 1'b1;
            if (count != 16'hFFFF) count <= count + 16'd1;
          end
          if (halt) begin
            state   <= CHECK;
            chk_idx <= '0;
          end
        end
        CHECK: begin
          if (entry_fail && mismatch_index == NoMismatch) mismatch_index <= chk_idx;
          if (chk_idx == LastIndex) begin
            state    <= DONE;
            finished <= 1'b1;
            success  <= (mismatch_index == NoMismatch) && !entry_fail &&
                        (count == 16'(NOut));
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Randomized and directed bench for out_channel_checker against a
// queue-based model of "last word written to each slot" semantics.
module tb_out_channel_checker;

  localparam int W  = 12;
  localparam int N  = 6;
  localparam int IW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [IW-1:0] load_index;
  logic [W-1:0]  load_data;
  logic          start;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          halt;
  logic          finished;
  logic          success;
  logic [15:0]   count;
  logic [IW-1:0] mismatch_index;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_tab [N];

  out_channel_checker #(.MemoryElementWidth(W), .NOut(N)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_index(load_index),
    .load_data(load_data), .start(start), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .halt(halt), .finished(finished), .success(success),
    .count(count), .mismatch_index(mismatch_index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic load_table(input logic [W-1:0] t [N]);
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1; load_index = IW'(i); load_data = t[i];
      exp_tab[i] = t[i];
      @(negedge clock);
    end
    // Out-of-range indices must be ignored; the model leaves the table alone.
    load_index = IW'(N); load_data = $urandom;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  // Run one capture: start, feed words, halt, then compare against the model.
  task automatic run(input string tag, input logic [W-1:0] words [$],
                     input bit halt_last, input bit noisy);
    logic [W-1:0] slot [N];
    bit           wr   [N];
    int           exp_mis, exp_cnt, cycles;
    bit           exp_ok;

    start = 1'b1; @(negedge clock); start = 1'b0;
    check({tag, " ready"}, out_ready, 1);
    check({tag, " fin_clr"}, finished, 0);

    foreach (words[k]) begin
      if (noisy) begin
        while ($urandom_range(0, 2) == 0) begin
          out_valid  = 1'b0;
          load_valid = ($urandom_range(0, 1) == 1);
          load_index = IW'($urandom_range(0, N - 1));
          load_data  = $urandom;
          @(negedge clock);
        end
        load_valid = 1'b0;
      end
      out_valid = 1'b1; out_data = words[k];
      if (halt_last && k == words.size() - 1) halt = 1'b1;
      @(negedge clock);
    end
    out_valid = 1'b0;
    if (!(halt_last && words.size() > 0)) begin
      halt = 1'b1; @(negedge clock);
    end
    halt = 1'b0;

    cycles = 1;
    while (!finished && cycles < 20) begin
      check({tag, " busy_ready"}, out_ready, 0);
      @(negedge clock); cycles++;
    end
    check({tag, " latency"}, cycles, N + 1);

    for (int i = 0; i < N; i++) wr[i] = 0;
    foreach (words[k]) begin
      slot[k % N] = words[k];
      wr[k % N]   = 1;
    end
    exp_mis = N;
    for (int i = N - 1; i >= 0; i--)
      if (!wr[i] || slot[i] != exp_tab[i]) exp_mis = i;
    exp_cnt = words.size();
    exp_ok  = (exp_mis == N) && (exp_cnt == N);

    check({tag, " finished"}, finished, 1);
    check({tag, " success"}, success, exp_ok);
    check({tag, " count"}, count, exp_cnt);
    check({tag, " mismatch"}, mismatch_index, exp_mis);

    halt = 1'b1; @(negedge clock); halt = 1'b0;
    check({tag, " done_hold"}, {finished, success, count}, {1'b1, exp_ok, 16'(exp_cnt)});
  endtask

  initial begin
    logic [W-1:0] tab [N];
    logic [W-1:0] q [$];

    reset = 1'b1; load_valid = 0; load_index = '0; load_data = '0;
    start = 0; out_valid = 0; out_data = '0; halt = 0;
    #12;
    check("rst ready", out_ready, 0);
    check("rst finished", finished, 0);
    check("rst success", success, 0);
    check("rst count", count, 0);
    check("rst mismatch", mismatch_index, N);
    @(negedge clock); reset = 1'b0;

    // IDLE ignores the channel and halt.
    out_valid = 1'b1; out_data = 12'd5; halt = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("idle ready", out_ready, 0);
    end
    out_valid = 1'b0; halt = 1'b0;
    check("idle count", count, 0);
    check("idle finished", finished, 0);

    tab = '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};
    load_table(tab);

    run("pass",     '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11}, 0, 0);
    run("bad3",     '{12'd3, 12'd33, 12'd2, 12'd99, 12'd1, 12'd11}, 0, 0);
    run("short",    '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1}, 0, 0);
    run("wrap",     '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11, 12'd7, 12'd7}, 0, 0);
    run("haltlast", '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11}, 1, 0);

    // start and halt together in DONE: start wins.
    start = 1'b1; halt = 1'b1; @(negedge clock); start = 1'b0; halt = 1'b0;
    check("start_wins ready", out_ready, 1);
    out_valid = 1'b1; out_data = 12'd3; @(negedge clock);
    out_data = 12'd33; @(negedge clock);
    out_valid = 1'b0;
    check("mid count", count, 2);

    // Asynchronous reset away from any clock edge.
    #2 reset = 1'b1;
    #1;
    check("async ready", out_ready, 0);
    check("async count", count, 0);
    check("async mismatch", mismatch_index, N);
    check("async finished", {finished, success}, 0);
    @(negedge clock); reset = 1'b0;
    run("after_rst", '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11}, 0, 0);

    // Randomized runs with gaps, ignored loads during capture, and reloads.
    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 0) begin
        for (int i = 0; i < N; i++) tab[i] = W'($urandom);
        load_table(tab);
      end
      q = {};
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < N; i++) q.push_back(exp_tab[i]);
        if ($urandom_range(0, 2) == 0) q[$urandom_range(0, N - 1)] ^= W'(1 << $urandom_range(0, W - 1));
      end else begin
        int len = $urandom_range(0, 2 * N);
        for (int i = 0; i < len; i++)
          q.push_back(($urandom_range(0, 1) == 1) ? exp_tab[i % N] : W'($urandom));
      end
      run($sformatf("rnd%0d", r), q, ($urandom_range(0, 1) == 1), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
